// File: rtl/skeeball_game_ctrl.sv
// Skeeball game sequencer: arms a game on start, scores hole hits, counts balls
// and the game clock, and locks the sensors out for a few ticks after each ball.
module skeeball_game_ctrl #(
  parameter int NUM_BALLS = 9,
  parameter int GAME_SECS = 60,
  parameter int HOLD_SECS = 5,
  parameter int SCORE_W   = 10
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               tick_1hz,
  input  logic               start_btn,
  input  logic [4:0]         hole,
  input  logic               gutter,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         balls_left,
  output logic [7:0]         secs_left,
  output logic               game_over
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } state_t;

  // Headroom so the largest award can be added before saturating.
  localparam int SUM_W = SCORE_W + 7;

  state_t             state_reg, state_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [3:0]         balls_reg, balls_next;
  logic [7:0]         secs_reg, secs_next;
  logic [3:0]         hold_reg, hold_next;
  logic               game_over_reg, game_over_next;

  logic [6:0]         pts [5];
  logic [6:0]         award;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [3:0]         ball_dec;
  logic               expire;
  logic               hold_exit;

  // Each bit only contributes when no higher bit is set, so at most one is non-zero.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_pts
      assign pts[gi] = (hole[gi] && ((hole >> (gi + 1)) == 5'd0)) ? 7'(10 * (gi + 1)) : 7'd0;
    end
  endgenerate

  always_comb begin
    award = 7'd0;
    for (int i = 0; i < 5; i++) award = award | pts[i];
  end

  always_comb begin
    state_next     = state_reg;
    score_next     = score_reg;
    balls_next     = balls_reg;
    secs_next      = secs_reg;
    hold_next      = hold_reg;
    game_over_next = 1'b0;

    expire    = tick_1hz && (secs_reg == 8'd1);
    hold_exit = tick_1hz && (hold_reg == 4'd1);
    score_sum = SUM_W'(score_reg) + SUM_W'(award);
    score_sat = (|score_sum[SUM_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    ball_dec  = (balls_reg != 4'd0) ? balls_reg - 4'd1 : 4'd0;

    case (state_reg)
      IDLE, OVER: begin
        if (start_btn) begin
          state_next = PLAY;
          score_next = '0;
          balls_next = 4'(NUM_BALLS);
          secs_next  = 8'(GAME_SECS);
          hold_next  = 4'd0;
        end
      end
      PLAY: begin
        if (tick_1hz && (secs_reg != 8'd0)) secs_next = secs_reg - 8'd1;
        if (hole != 5'd0) begin
          score_next = score_sat;
          balls_next = ball_dec;
          hold_next  = 4'(HOLD_SECS);
          state_next = HOLD;
        end else if (gutter) begin
          balls_next = ball_dec;
          hold_next  = 4'(HOLD_SECS);
          state_next = HOLD;
        end
        if (expire) state_next = OVER;
      end
      HOLD: begin
        if (tick_1hz) begin
          if (secs_reg != 8'd0) secs_next = secs_reg - 8'd1;
          if (hold_reg != 4'd0) hold_next = hold_reg - 4'd1;
        end
        if (hold_exit) state_next = (balls_reg == 4'd0) ? OVER : PLAY;
        // Clock expiry aborts the lockout.
        if (expire) state_next = OVER;
      end
      default: state_next = IDLE;
    endcase

    game_over_next = (state_next == OVER) && (state_reg != OVER);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      score_reg     <= '0;
      balls_reg     <= 4'd0;
      secs_reg      <= 8'd0;
      hold_reg      <= 4'd0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      score_reg     <= score_next;
      balls_reg     <= balls_next;
      secs_reg      <= secs_next;
      hold_reg      <= hold_next;
      game_over_reg <= game_over_next;
    end
  end

  assign state      = state_reg;
  assign score      = score_reg;
  assign balls_left = balls_reg;
  assign secs_left  = secs_reg;
  assign game_over  = game_over_reg;

endmodule
